// File: rtl/bp_be_multi_stream_prefetch_generator_pkg.sv
// Shared types and constants for the multi-stream strided prefetch generator:
// stream FSM states, the dispatch packet layout and the prefetch.r encoding.
package bp_be_multi_stream_prefetch_generator_pkg;

  localparam int unsigned vaddr_width_gp        = 39;
  localparam int unsigned dcache_block_width_gp = 512;
  localparam int unsigned dpath_width_gp        = 64;
  localparam int unsigned block_offset_width_gp = $clog2(dcache_block_width_gp / 8);

  localparam logic [6:0] op_imm_opcode_gp     = 7'b0010011;
  localparam logic [2:0] prefetch_r_funct3_gp = 3'b110;
  localparam logic [4:0] prefetch_r_rs2_gp    = 5'b00001;

  typedef enum logic [1:0] {
    e_pf_idle,
    e_pf_walk,
    e_pf_send
  } bp_be_pf_stream_state_e;

  typedef enum logic [3:0] {
    e_dcache_op_lb = 4'h0,
    e_dcache_op_lh = 4'h1,
    e_dcache_op_lw = 4'h2,
    e_dcache_op_ld = 4'h3
  } bp_be_dcache_fu_op_e;

  typedef enum logic [1:0] {
    e_int_byte  = 2'd0,
    e_int_hword = 2'd1,
    e_int_word  = 2'd2,
    e_int_dword = 2'd3
  } bp_be_int_tag_e;

  typedef struct packed {
    logic                pipe_int_v;
    logic                pipe_mem_early_v;
    logic                pipe_mem_final_v;
    logic                spec_w_v;
    logic                irf_w_v;
    logic                dcache_r_v;
    logic                dcache_w_v;
    logic                mem_v;
    logic                prefetch;
    logic                irs1_unsigned;
    bp_be_dcache_fu_op_e fu_op;
    bp_be_int_tag_e      irs1_tag;
    bp_be_int_tag_e      ird_tag;
  } bp_be_decode_s;

  typedef struct packed {
    logic                      v;
    logic                      nspec_v;
    logic [vaddr_width_gp-1:0] pc;
    logic [31:0]               instr;
    bp_be_decode_s             decode;
    logic [dpath_width_gp-1:0] rs1;
  } bp_be_dispatch_pkt_s;

  localparam int unsigned dispatch_pkt_width_gp = $bits(bp_be_dispatch_pkt_s);

  function automatic bp_be_dispatch_pkt_s build_prefetch_pkt(
    input logic [vaddr_width_gp-1:0] pc,
    input logic [vaddr_width_gp-1:0] addr
  );
    bp_be_dispatch_pkt_s pkt;
    pkt                         = '0;
    pkt.v                       = 1'b1;
    pkt.nspec_v                 = 1'b1;
    pkt.pc                      = pc;
    pkt.instr                   = {7'b0, prefetch_r_rs2_gp, 5'b0, prefetch_r_funct3_gp, 5'b0,
                                   op_imm_opcode_gp};
    pkt.decode.pipe_mem_early_v = 1'b1;
    pkt.decode.spec_w_v         = 1'b1;
    pkt.decode.dcache_r_v       = 1'b1;
    pkt.decode.mem_v            = 1'b1;
    pkt.decode.prefetch         = 1'b1;
    pkt.decode.irs1_unsigned    = 1'b1;
    pkt.decode.fu_op            = e_dcache_op_lb;
    pkt.decode.irs1_tag         = e_int_word;
    pkt.decode.ird_tag          = e_int_word;
    pkt.rs1                     = dpath_width_gp'(addr);
    return pkt;
  endfunction

endpackage

// File: rtl/bp_be_multi_stream_prefetch_generator_if.sv
// Training-request and prefetch-dispatch handshake of the prefetch generator.
interface bp_be_multi_stream_prefetch_generator_if #(
  parameter int unsigned stride_width_p = 12,
  parameter int unsigned loop_range_p   = 8
) ();
  import bp_be_multi_stream_prefetch_generator_pkg::*;

  logic                      req_v;
  logic                      ready_and;
  logic [vaddr_width_gp-1:0] pc;
  logic [vaddr_width_gp-1:0] eff_addr;
  logic [stride_width_p-1:0] stride;
  logic [loop_range_p-1:0]   loop_counter;
  logic                      pkt_v;
  logic                      yumi;
  bp_be_dispatch_pkt_s       dispatch_pkt;

  modport master (
    output req_v, pc, eff_addr, stride, loop_counter, yumi,
    input  ready_and, pkt_v, dispatch_pkt
  );

  modport slave (
    input  req_v, pc, eff_addr, stride, loop_counter, yumi,
    output ready_and, pkt_v, dispatch_pkt
  );
endinterface

// File: rtl/bp_be_multi_stream_prefetch_generator_stream.sv
// One prefetch stream slot: walks addr by stride and parks in SEND whenever the
// walk enters a new dcache block, until its packet is consumed.
module bp_be_multi_stream_prefetch_generator_stream
  import bp_be_multi_stream_prefetch_generator_pkg::*;
#(
  parameter int unsigned loop_range_p = 8
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      flush_i,
  input  logic                      alloc_i,
  input  logic [vaddr_width_gp-1:0] pc_i,
  input  logic [vaddr_width_gp-1:0] addr_i,
  input  logic [vaddr_width_gp-1:0] stride_i,
  input  logic [loop_range_p-1:0]   count_i,
  input  logic                      consume_i,
  output bp_be_pf_stream_state_e    state_o,
  output logic [vaddr_width_gp-1:0] pc_o,
  output logic [vaddr_width_gp-1:0] addr_o
);

  bp_be_pf_stream_state_e    state_q, state_d;
  logic [vaddr_width_gp-1:0] pc_q, pc_d;
  logic [vaddr_width_gp-1:0] addr_q, addr_d;
  logic [vaddr_width_gp-1:0] stride_q, stride_d;
  logic [loop_range_p-1:0]   count_q, count_d;

  logic [vaddr_width_gp-1:0] walk_addr;
  logic [loop_range_p-1:0]   walk_count;
  logic                      crossed;

  assign walk_addr  = addr_q + stride_q;
  assign walk_count = count_q - loop_range_p'(1);
  assign crossed    = walk_addr[vaddr_width_gp-1:block_offset_width_gp]
                      != addr_q[vaddr_width_gp-1:block_offset_width_gp];

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    addr_d   = addr_q;
    stride_d = stride_q;
    count_d  = count_q;
    if (flush_i) begin
      state_d = e_pf_idle;
    end else if (alloc_i) begin
      // Retraining overwrites everything, including a pending SEND.
      state_d  = e_pf_walk;
      pc_d     = pc_i;
      addr_d   = addr_i;
      stride_d = stride_i;
      count_d  = count_i;
    end else begin
      unique case (state_q)
        e_pf_walk: begin
          addr_d  = walk_addr;
          count_d = walk_count;
          if (crossed)                state_d = e_pf_send;
          else if (walk_count == '0)  state_d = e_pf_idle;
          else                        state_d = e_pf_walk;
        end
        e_pf_send: begin
          if (consume_i) state_d = (count_q == '0) ? e_pf_idle : e_pf_walk;
        end
        default: state_d = e_pf_idle;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= e_pf_idle;
      pc_q     <= '0;
      addr_q   <= '0;
      stride_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      addr_q   <= addr_d;
      stride_q <= stride_d;
      count_q  <= count_d;
    end
  end

  assign state_o = state_q;
  assign pc_o    = pc_q;
  assign addr_o  = addr_q;

endmodule

// File: rtl/bp_be_multi_stream_prefetch_generator.sv
// Multi-stream strided prefetch generator: allocates/retrains stream slots by PC
// and merges their block-crossing prefetches through a round-robin arbiter.
module bp_be_multi_stream_prefetch_generator
  import bp_be_multi_stream_prefetch_generator_pkg::*;
#(
  parameter int unsigned streams_p      = 4,
  parameter int unsigned loop_range_p   = 8,
  parameter int unsigned stride_width_p = 12
) (
  input  logic                                          clk_i,
  input  logic                                          reset_i,
  input  logic                                          flush_i,
  bp_be_multi_stream_prefetch_generator_if.slave        pf_io,
  output logic [streams_p-1:0]                          active_o
);

  localparam int unsigned ptr_width_lp = (streams_p > 1) ? $clog2(streams_p) : 1;

  bp_be_pf_stream_state_e    slot_state [streams_p];
  logic [vaddr_width_gp-1:0] slot_pc    [streams_p];
  logic [vaddr_width_gp-1:0] slot_addr  [streams_p];

  logic [streams_p-1:0]      idle, send, match, alloc, consume;
  logic [vaddr_width_gp-1:0] stride_ext;
  logic                      ready, do_alloc, pkt_fire, match_found, idle_found, grant_found;
  logic [ptr_width_lp-1:0]   match_idx, idle_idx, alloc_idx, grant_idx, rr_idx;
  logic [ptr_width_lp-1:0]   ptr_q, ptr_d;

  assign stride_ext = {{(vaddr_width_gp - stride_width_p){pf_io.stride[stride_width_p-1]}},
                       pf_io.stride};

  always_comb begin
    match_found = 1'b0;
    idle_found  = 1'b0;
    match_idx   = '0;
    idle_idx    = '0;
    for (int i = 0; i < streams_p; i++) begin
      idle[i]  = (slot_state[i] == e_pf_idle);
      send[i]  = (slot_state[i] == e_pf_send);
      match[i] = !idle[i] && (slot_pc[i] == pf_io.pc);
      if (!match_found && match[i]) begin
        match_found = 1'b1;
        match_idx   = ptr_width_lp'(i);
      end
      if (!idle_found && idle[i]) begin
        idle_found = 1'b1;
        idle_idx   = ptr_width_lp'(i);
      end
    end
  end

  // Round-robin search over SEND slots starting at the pointer.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = ptr_q;
    rr_idx      = '0;
    for (int unsigned k = 0; k < streams_p; k++) begin
      rr_idx = ptr_width_lp'((32'(ptr_q) + k) % streams_p);
      if (!grant_found && send[rr_idx]) begin
        grant_found = 1'b1;
        grant_idx   = rr_idx;
      end
    end
  end

  assign ready     = !flush_i && (idle_found || match_found);
  assign do_alloc  = pf_io.req_v && ready && (pf_io.stride != '0) && (pf_io.loop_counter != '0);
  assign alloc_idx = match_found ? match_idx : idle_idx;
  assign pkt_fire  = pf_io.yumi && pf_io.pkt_v;

  always_comb begin
    for (int i = 0; i < streams_p; i++) begin
      alloc[i]   = do_alloc && (alloc_idx == ptr_width_lp'(i));
      consume[i] = pkt_fire && (grant_idx == ptr_width_lp'(i)) && !alloc[i];
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (pkt_fire && !alloc[grant_idx]) begin
      ptr_d = (grant_idx == ptr_width_lp'(streams_p - 1)) ? '0 : grant_idx + ptr_width_lp'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

  for (genvar g = 0; g < streams_p; g++) begin : g_slot
    bp_be_multi_stream_prefetch_generator_stream #(
      .loop_range_p (loop_range_p)
    ) u_stream (
      .clk_i     (clk_i),
      .reset_i   (reset_i),
      .flush_i   (flush_i),
      .alloc_i   (alloc[g]),
      .pc_i      (pf_io.pc),
      .addr_i    (pf_io.eff_addr),
      .stride_i  (stride_ext),
      .count_i   (pf_io.loop_counter),
      .consume_i (consume[g]),
      .state_o   (slot_state[g]),
      .pc_o      (slot_pc[g]),
      .addr_o    (slot_addr[g])
    );
  end

  assign pf_io.ready_and    = ready;
  assign pf_io.pkt_v        = !flush_i && grant_found;
  assign pf_io.dispatch_pkt = build_prefetch_pkt(slot_pc[grant_idx], slot_addr[grant_idx]);
  assign active_o           = ~idle;

  // A retrain must never target the slot whose packet is being consumed.
  assert property (@(posedge clk_i) disable iff (reset_i)
                   !(pkt_fire && alloc[grant_idx]));
  assert property (@(posedge clk_i) disable iff (reset_i) pf_io.yumi |-> pf_io.pkt_v);

endmodule

// File: doc/bp_be_multi_stream_prefetch_generator.md
Name: bp_be_multi_stream_prefetch_generator

Overview:
- Next-generation striding-load prefetch engine for the BE checker.
- Tracks up to streams_p independent strided streams. Each stream walks its address sequence with a signed stride and emits one prefetch dispatch packet each time the walk enters a new dcache block.
- Prefetches from all streams are merged onto a single dispatch-packet output by a round-robin arbiter, ahead of the dispatch mux. Supports flush and retraining of an active stream by PC.

Parameters:
- bp_params_p, e_bp_default_cfg: processor configuration; supplies vaddr_width_p, dcache_block_width_p and dpath_width_gp.
- streams_p, 4: number of concurrent stream slots; minimum 1.
- loop_range_p, 8: width of the iteration count.
- stride_width_p, 12: width of the stride, two's-complement signed.
- block_offset_width_lp (local), clog2(dcache_block_width_p/8): byte-offset bits within a block.
- dispatch_pkt_width_lp (local), bp_be_dispatch_pkt_width(vaddr_width_p): width of the output packet.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous, active-high reset.
- flush_i  in  1  kill all streams; e.g. pipeline flush or mispredict.
- v_i  in  1  stream-training request valid.
- ready_and_o  out  1  request can be accepted this cycle.
- pc_i  in  vaddr_width_p  PC of the striding load.
- eff_addr_i  in  vaddr_width_p  effective address of the demand access.
- stride_i  in  stride_width_p  signed byte stride.
- loop_counter_i  in  loop_range_p  remaining iterations to walk.
- v_o  out  1  prefetch packet valid.
- yumi_i  in  1  consumer takes the packet; legal only when v_o=1.
- dispatch_pkt_o  out  dispatch_pkt_width_lp  prefetch dispatch packet.
- active_o  out  streams_p  per-slot non-IDLE status, for debug and perf counters.

Behaviour:
- Reset: all slots IDLE, round-robin pointer at 0, v_o=0, active_o=0. ready_and_o=1 after reset.
- Each slot has registers valid, pc, addr (vaddr_width_p), stride (sign-extended to vaddr_width_p), count (loop_range_p), and a state.
- Slot states:
  - IDLE->WALK on allocation.
  - WALK: each cycle, addr<=addr+stride and count<=count-1.
    - If the new block (addr[vaddr-1:block_offset]) differs from the old block -> SEND.
    - Else if the new count==0 -> IDLE.
    - Else stay in WALK.
  - SEND: hold until granted and yumi_i. Then -> IDLE if count==0, else -> WALK.
- Address arithmetic: modulo 2^vaddr_width_p; wrap-around is silent.
- The initial block (the demand access) is never prefetched.
- Acceptance: ready_and_o = ~flush_i & (any IDLE slot | any slot whose pc==pc_i).
  - A request is accepted on v_i & ready_and_o.
  - A PC match takes priority: that slot is retrained (fields overwritten, -> WALK), discarding any pending SEND.
  - Otherwise the lowest-index IDLE slot is allocated.
  - A request with stride==0 or loop_counter_i==0 is accepted but allocates nothing; it does not retrain a matching slot.
- Latency: request accepted in cycle t; first WALK step in t+1; a block crossing detected in cycle t+k gives v_o at the earliest in t+k+1.
- Output:
  - v_o = ~flush_i & (any slot in SEND).
  - Round-robin grant over SEND slots, starting from the pointer. The pointer advances past the granted slot only on yumi_i.
  - The packet is therefore stable while v_o=1 without yumi_i, unless a higher-priority retrain removes the granted slot.
- Packet contents:
  - v=1, nspec_v=1, pc = slot pc, rs1 = slot addr zero-extended to dpath_width_gp.
  - instr = prefetch.r encoding: OP-IMM opcode, funct3=110, rs2=00001, other fields 0.
  - decode has pipe_mem_early_v, spec_w_v, dcache_r_v, mem_v, prefetch and irs1_unsigned set; fu_op=e_dcache_op_lb; irs1_tag and ird_tag = e_int_word. All other fields are 0.
- Flush: v_o and ready_and_o are forced to 0 in the same cycle; all slots go IDLE at the next edge.
  - Flush wins over a simultaneous v_i (the request is dropped) and over yumi_i. yumi_i during flush is illegal.
- Simultaneous accept and grant on the same slot: the retrain wins; the old packet is not marked consumed and the pointer does not advance. The consumer must not assert yumi_i for it. Retraining therefore requires pc_i not to match the granted slot when yumi_i=1; an assertion checks this.
- Reset mid-operation: identical to the reset state at the next edge.

Decomposition:
- Shared package (bp_be_pkg): typedef enum bp_be_pf_stream_state_e {e_pf_idle, e_pf_walk, e_pf_send}, plus a localparam for the prefetch.r funct3/rs2 encoding.
- Sub-module bp_be_prefetch_stream: one slot's registers, FSM and block-crossing compare. It is instantiated streams_p times.
- Use bsg_arb_round_robin for the grant and bsg_priority_encode for allocation.

Test Plan:
- 512-bit block: eff_addr=0x1000, stride=8, count=16 -> exactly two packets, rs1=0x1040 then rs1=0x1080; slot returns to IDLE; active_o=0.
- eff_addr=0x1040, stride=-8 (0xFF8), count=2 -> exactly one packet, rs1=0x1038; IDLE after 2 WALK cycles plus the SEND.
- Two streams, pc A (0x1000, +128, 3) and pc B (0x8000, +128, 3), yumi_i held 1 -> packets alternate A/B: 0x1080, 0x8080, 0x1100, 0x8100, 0x1180, 0x8180.
- v_o held with yumi_i=0 for 10 cycles -> dispatch_pkt_o unchanged; slot stays in SEND; count does not decrement.
- All streams_p slots busy, new distinct pc -> ready_and_o=0. Same-pc request -> ready_and_o=1 and the slot retrains to the new address.
- flush_i together with v_i while two slots are in SEND -> v_o=0 that cycle, all slots IDLE next cycle, no packet emitted, request dropped.
